// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing, a single-outstanding memory request FSM and a 2-entry decode buffer.
// Optional feature: define IF_PERF_COUNT_EN to add the fetchCount/stallCount performance counters.
module instruction_fetch (
    input  logic        clock,
    input  logic        resetn,
    output logic        imemReq,
    output logic [15:0] imemAddr,
    input  logic        imemValid,
    input  logic [15:0] imemData,
    input  logic        redirect,
    input  logic [15:0] redirectTarget,
    input  logic        idStall,
    output logic        outValid,
    output logic [2:0]  rs,
    output logic [2:0]  rt,
    output logic [2:0]  rd,
    output logic [1:0]  funct,
    output logic [7:0]  addressjump,
    output logic [3:0]  opcode,
    output logic [15:0] PC4
`ifdef IF_PERF_COUNT_EN
    ,
    output logic [15:0] fetchCount,
    output logic [15:0] stallCount
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] pc_r;
    logic [15:0] pc_s;
    logic        run_r;
    logic [15:0] instr_r [2];
    logic [15:0] pc4_r   [2];
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic [1:0]  count_r;
    logic        req_s;
    logic        push_s;
    logic        pop_s;
    logic        valid_s;
    logic [15:0] head_instr_s;
    logic [15:0] head_pc4_s;

    assign valid_s = (count_r != 2'd0);
    assign pop_s   = valid_s & ~idStall & ~redirect;

    // Next state, next PC, request issue and buffer push decisions
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        req_s   = 1'b0;
        push_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (redirect) begin
                    pc_s    = redirectTarget;
                    state_s = IDLE;
                end else if (run_r && (count_r != 2'd2)) begin
                    req_s   = 1'b1;
                    pc_s    = pc_r + 16'd1;
                    state_s = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_s = redirectTarget;
                    if (imemValid) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DISCARD;
                    end
                end else if (imemValid) begin
                    push_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            DISCARD: begin
                // The stale response is still owed; it is swallowed before fetching resumes
                if (redirect) begin
                    pc_s = redirectTarget;
                end else begin
                    pc_s = pc_r;
                end
                if (imemValid) begin
                    state_s = IDLE;
                end else begin
                    state_s = DISCARD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, PC and a flag that holds off requests for the first cycle after reset release
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
            pc_r    <= 16'h0000;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            run_r   <= 1'b1;
        end
    end

    // Decode buffer storage; in WAIT without redirect pc_r already holds request address + 1
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            instr_r[0] <= 16'h0000;
            instr_r[1] <= 16'h0000;
            pc4_r[0]   <= 16'h0000;
            pc4_r[1]   <= 16'h0000;
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
        end else if (redirect) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                instr_r[wr_ptr_r] <= imemData;
                pc4_r[wr_ptr_r]   <= pc_r;
                wr_ptr_r          <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head entry selection; an empty buffer presents all-zero fields
    always_comb begin
        head_instr_s = 16'h0000;
        head_pc4_s   = 16'h0000;
        if (valid_s) begin
            head_instr_s = instr_r[rd_ptr_r];
            head_pc4_s   = pc4_r[rd_ptr_r];
        end else begin
            head_instr_s = 16'h0000;
            head_pc4_s   = 16'h0000;
        end
    end

    assign imemReq     = req_s;
    assign imemAddr    = pc_r;
    assign outValid    = valid_s;
    assign opcode      = head_instr_s[15:12];
    assign rs          = head_instr_s[11:9];
    assign rt          = head_instr_s[8:6];
    assign rd          = head_instr_s[5:3];
    assign funct       = head_instr_s[1:0];
    assign addressjump = head_instr_s[7:0];
    assign PC4         = head_pc4_s;

`ifdef IF_PERF_COUNT_EN
    logic [15:0] fetch_count_r;
    logic [15:0] stall_count_r;

    // Pop and decode-stall event counters, free-running with wrap
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fetch_count_r <= 16'd0;
            stall_count_r <= 16'd0;
        end else begin
            if (pop_s) begin
                fetch_count_r <= fetch_count_r + 16'd1;
            end
            if (valid_s && idStall) begin
                stall_count_r <= stall_count_r + 16'd1;
            end
        end
    end

    assign fetchCount = fetch_count_r;
    assign stallCount = stall_count_r;
`endif

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The interface SHALL have one clock and an asynchronous, active-low reset, with ports listed below (clock and reset first).
REQ-002 clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 resetn  input  1  asynchronous reset, active low.
REQ-004 imemReq  output  1  instruction memory read request; held for one cycle per request.
REQ-005 imemAddr  output  16  word address of the request (current PC).
REQ-006 imemValid  input  1  response strobe from memory; comes at least 1 cycle after imemReq.
REQ-007 imemData  input  16  instruction word returned with imemValid.
REQ-008 redirect  input  1  branch/jump taken; flushes the stage.
REQ-009 redirectTarget  input  16  new PC when redirect=1.
REQ-010 idStall  input  1  decode stage cannot accept an instruction this cycle.
REQ-011 outValid  output  1  the head instruction is presented to decode.
REQ-012 rs, rt, rd  output  3 each  instr[11:9], [8:6], [5:3] of the head entry.
REQ-013 funct  output  2  instr[1:0]; addressjump  output  8  instr[7:0]; opcode  output  4  instr[15:12].
REQ-014 PC4  output  16  head instruction address + 1 (word-addressed).

Function
REQ-015 The PC SHALL be 16-bit and wrap from 0xFFFF to 0x0000; PC SHALL increment by 1 when a request is issued.
REQ-016 Buffer: 2-entry FIFO of {instr, PC4}; outValid SHALL be 1 iff count != 0; field outputs SHALL be decoded combinationally from the head entry.
REQ-017 Pop SHALL occur when outValid=1 and idStall=0 and redirect=0.
REQ-018 FSM states: IDLE, WAIT, DISCARD; at most one request SHALL be outstanding.
REQ-019 IDLE: imemReq=1, imemAddr=PC when count<2 and redirect=0, and the next state is WAIT; otherwise stay in IDLE.
REQ-020 WAIT: on imemValid=1 push {imemData, address+1} and go to IDLE; a pop and a push in the same cycle SHALL both take effect.
REQ-021 Redirect SHALL have top priority: FIFO cleared (count=0), PC<=redirectTarget, no request that cycle.
REQ-022 Redirect in WAIT with imemValid=0 SHALL go to DISCARD; redirect in WAIT with imemValid=1 SHALL drop the data and go to IDLE.
REQ-023 DISCARD: the next imemValid SHALL be dropped with no push, then go to IDLE; a redirect in DISCARD SHALL update PC and stay in DISCARD.
REQ-024 A full FIFO (count=2) SHALL never receive a push; this follows from REQ-019.
REQ-025 Best-case throughput: one instruction per 2 cycles with 1-cycle memory latency.

Reset
REQ-026 On resetn=0 (asynchronous): PC=0x0000, state=IDLE, count=0, imemReq=0, outValid=0, and all field outputs and PC4 read 0.
REQ-027 A response arriving after reset is released while the FSM is in IDLE SHALL be ignored.

Configuration
REQ-028 The macro IF_PERF_COUNT_EN SHALL enable the extra outputs fetchCount (16) and stallCount (16).
REQ-029 With the macro defined: fetchCount SHALL increment on every pop, stallCount SHALL increment on every cycle with outValid=1 and idStall=1, both wrap, and both reset to 0.
REQ-030 Without the macro, neither port nor counter logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset then release, memory latency 1, data 0x1A5B at addr 0 -> imemAddr=0, then outValid=1, opcode=1, rs=5, rt=1, rd=3, funct=3, addressjump=0x5B, PC4=1.
REQ-032 idStall held at 1 for 10 cycles -> exactly 2 entries buffered, imemReq stays 0, the FIFO order is kept after release.
REQ-033 Redirect to 0x0040 during WAIT with the response 3 cycles later -> that response is dropped (DISCARD) and the next imemAddr=0x0040.
REQ-034 Redirect in the same cycle as imemValid -> no push, count=0, next request at the target.
REQ-035 PC=0xFFFF fetch -> PC4=0x0000 and the next imemAddr=0x0000.
REQ-036 Assert resetn=0 mid-WAIT -> all outputs are 0 immediately; with IF_PERF_COUNT_EN, 5 pops and 3 stall cycles -> fetchCount=5, stallCount=3.
